// File: rtl/div_iter_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_pkg
// Shared definitions for the iterative radix-2 divider of the MiniMIPS32
// execute stage: FSM state encoding and the aluop codes that EXE decodes to
// drive the divider's start/sign inputs.
// -----------------------------------------------------------------------------
package div_iter_pkg;

  // Divider FSM states. The explicit 2-bit base type is the state bus width.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // aluop codes that select the divider in EXE (DIV -> signed, DIVU -> unsigned).
  localparam logic [7:0] ALUOP_DIV  = 8'h16;
  localparam logic [7:0] ALUOP_DIVU = 8'h17;

endpackage : div_iter_pkg

// File: rtl/div_iter_step.sv
// -----------------------------------------------------------------------------
// div_iter_step
// One combinational restoring-division step. The quotient register doubles
// as the dividend shift register: its MSB is shifted into the partial
// remainder, and the new quotient bit is shifted in at its LSB.
//
// Ports:
//   rem_i  [WIDTH-1:0]  partial remainder (always < divisor)
//   quo_i  [WIDTH-1:0]  quotient / remaining-dividend shift register
//   dvs_i  [WIDTH-1:0]  divisor magnitude
//   rem_o  [WIDTH-1:0]  next partial remainder
//   quo_o  [WIDTH-1:0]  next quotient shift register
// -----------------------------------------------------------------------------
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // The shifted remainder needs WIDTH+1 bits for the compare, but once the
  // divisor is subtracted the result is below the divisor, so WIDTH bits of
  // the subtraction are exact.
  assign trial = {rem_i, quo_i[WIDTH-1]};
  assign ge    = (trial >= {1'b0, dvs_i});
  assign diff  = trial[WIDTH-1:0] - dvs_i;

  assign rem_o = ge ? diff : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ge};

endmodule : div_iter_step

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Iterative radix-2 signed/unsigned divider (DIV/DIVU), one quotient bit per
// cycle. Holds the pipeline via stallreq_exe while working, presents the
// result as {HI,LO} = {remainder, quotient}, and is cancelled by CP0 flush.
//
// Ports:
//   cpu_clk_50M           clock
//   cpu_rst               synchronous active-high reset
//   start, sign           request a division (sign=1: DIV, 0: DIVU), IDLE only
//   dividend, divisor     operands, sampled with start
//   flush                 abort any operation, priority over start/ack
//   ack                   consumer takes the result, DONE -> IDLE
//   busy                  state != IDLE
//   stallreq_exe          (IDLE & start & !flush) | CALC, combinational
//   valid                 result available (DONE)
//   quotient, remainder   registered results
//   hilo                  {remainder, quotient}
// -----------------------------------------------------------------------------
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               flush,
  input  logic               ack,
  output logic               busy,
  output logic               stallreq_exe,
  output logic               valid,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] hilo
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q,     state_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] quo_q,       quo_d;
  logic [WIDTH-1:0] dvs_q,       dvs_d;
  logic             neg_quo_q,   neg_quo_d;
  logic             neg_rem_q,   neg_rem_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // Two's-complement magnitudes. The most-negative value maps onto itself,
  // which read as unsigned is exactly its magnitude, so MIN/-1 wraps cleanly.
  assign dividend_abs = (sign && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
  assign divisor_abs  = (sign && divisor[WIDTH-1])  ? (~divisor  + WIDTH'(1)) : divisor;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            neg_quo_d = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = sign & dividend[WIDTH-1];
            if (divisor == '0) begin
              // Division by zero: no iteration and no sign fix-up.
              quotient_d  = '1;
              remainder_d = dividend;
              state_d     = DIV_DONE;
            end else begin
              rem_d   = '0;
              quo_d   = dividend_abs;
              dvs_d   = divisor_abs;
              count_d = '0;
              state_d = DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_LAST) begin
            quotient_d  = neg_quo_q ? (~step_quo + WIDTH'(1)) : step_quo;
            remainder_d = neg_rem_q ? (~step_rem + WIDTH'(1)) : step_rem;
            state_d     = DIV_DONE;
          end
        end
        DIV_DONE: begin
          // A new start here is ignored; only ack releases the result.
          if (ack) begin
            state_d = DIV_IDLE;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (cpu_rst) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy         = (state_q != DIV_IDLE);
  assign valid        = (state_q == DIV_DONE);
  // Low in DONE so the instruction advances together with the result.
  assign stallreq_exe = ((state_q == DIV_IDLE) && start && !flush) || (state_q == DIV_CALC);
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign hilo         = {remainder_q, quotient_q};

endmodule : div_iter

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Directed bench for div_iter at WIDTH=32 and WIDTH=8. Cycle n is the time
// between clock edge n and edge n+1; inputs change and outputs are sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_div_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // 32-bit instance
  logic        rst32, start32, sign32, flush32, ack32;
  logic [31:0] dd32, dv32;
  logic        busy32, stall32, valid32;
  logic [31:0] quo32, rem32;
  logic [63:0] hilo32;

  // 8-bit instance
  logic       rst8, start8, sign8, flush8, ack8;
  logic [7:0] dd8, dv8;
  logic       busy8, stall8, valid8;
  logic [7:0] quo8, rem8;
  logic [15:0] hilo8;

  div_iter #(.WIDTH(32)) dut32 (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst32),
    .start       (start32),
    .sign        (sign32),
    .dividend    (dd32),
    .divisor     (dv32),
    .flush       (flush32),
    .ack         (ack32),
    .busy        (busy32),
    .stallreq_exe(stall32),
    .valid       (valid32),
    .quotient    (quo32),
    .remainder   (rem32),
    .hilo        (hilo32)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst8),
    .start       (start8),
    .sign        (sign8),
    .dividend    (dd8),
    .divisor     (dv8),
    .flush       (flush8),
    .ack         (ack8),
    .busy        (busy8),
    .stallreq_exe(stall8),
    .valid       (valid8),
    .quotient    (quo8),
    .remainder   (rem8),
    .hilo        (hilo8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one 32-bit division, wait (bounded) for valid, check latency and
  // results, then acknowledge and check valid drops.
  task automatic run32(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_q,
                       input logic [31:0] exp_r, input int exp_lat);
    int cyc;
    sign32 = s; dd32 = a; dv32 = b; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    cyc = 1;
    while (!valid32 && cyc < 60) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " quotient"}, 64'(quo32), 64'(exp_q));
    check({tag, " remainder"}, 64'(rem32), 64'(exp_r));
    check({tag, " hilo"}, hilo32, {exp_r, exp_q});
    ack32 = 1'b1;
    tick();
    ack32 = 1'b0;
    check({tag, " valid after ack"}, 64'(valid32), 64'(0));
  endtask

  initial begin
    int  cyc;
    logic seen;

    rst32 = 1'b1; start32 = 1'b0; sign32 = 1'b0; flush32 = 1'b0; ack32 = 1'b0;
    dd32 = '0; dv32 = '0;
    rst8 = 1'b1; start8 = 1'b0; sign8 = 1'b0; flush8 = 1'b0; ack8 = 1'b0;
    dd8 = '0; dv8 = '0;
    tick();
    tick();
    rst32 = 1'b0;
    rst8  = 1'b0;

    // Reset state
    check("reset busy32",  64'(busy32),  64'(0));
    check("reset valid32", 64'(valid32), 64'(0));
    check("reset stall32", 64'(stall32), 64'(0));
    check("reset hilo32",  hilo32,       64'(0));
    check("reset hilo8",   64'(hilo8),   64'(0));

    // Unsigned 100 / 7 with cycle-by-cycle stall/valid tracking
    sign32 = 1'b0; dd32 = 32'd100; dv32 = 32'd7; start32 = 1'b1;
    #1;
    check("u100/7 stall c0", 64'(stall32), 64'(1));
    tick();
    start32 = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (!stall32 || valid32 || !busy32) seen = 1'b1;
      if (c < 32) tick();
    end
    check("u100/7 calc c1-32 stall/busy/!valid", 64'(seen), 64'(0));
    tick();
    check("u100/7 valid c33", 64'(valid32), 64'(1));
    check("u100/7 stall c33", 64'(stall32), 64'(0));
    check("u100/7 quotient",  64'(quo32),   64'(14));
    check("u100/7 remainder", 64'(rem32),   64'(2));
    check("u100/7 hilo",      hilo32,       64'h00000002_0000000E);

    // Hold in DONE for 5 cycles with ack low; a start here is ignored.
    for (int c = 0; c < 5; c++) begin
      start32 = (c == 2);
      sign32 = 1'b0; dd32 = 32'd9; dv32 = 32'd4;
      tick();
      check("hold valid", 64'(valid32), 64'(1));
      check("hold hilo",  hilo32,       64'h00000002_0000000E);
    end
    start32 = 1'b0;
    ack32 = 1'b1;
    tick();
    ack32 = 1'b0;
    check("ack valid drop", 64'(valid32), 64'(0));
    check("ack busy drop",  64'(busy32),  64'(0));

    // Signed cases and boundaries
    run32("s-7/2",  1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run32("s7/-2",  1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33);
    run32("sMIN/-1",1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        33);
    run32("uMAX/1", 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        33);

    // Divide by zero: valid in cycle 1, stall only in cycle 0
    sign32 = 1'b0; dd32 = 32'd5; dv32 = 32'd0; start32 = 1'b1;
    #1;
    check("dz stall c0", 64'(stall32), 64'(1));
    tick();
    start32 = 1'b0;
    check("dz valid c1", 64'(valid32), 64'(1));
    check("dz stall c1", 64'(stall32), 64'(0));
    check("dz quotient", 64'(quo32),   64'hFFFFFFFF);
    check("dz remainder",64'(rem32),   64'(5));
    ack32 = 1'b1;
    tick();
    ack32 = 1'b0;

    // Signed divide by zero keeps the raw dividend
    run32("sdz", 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1);

    // Flush in CALC cycle 10
    sign32 = 1'b0; dd32 = 32'd100; dv32 = 32'd7; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    check("flush busy c10", 64'(busy32), 64'(1));
    flush32 = 1'b1;
    tick();
    flush32 = 1'b0;
    check("flush busy c11",  64'(busy32),  64'(0));
    check("flush stall c11", 64'(stall32), 64'(0));
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (valid32) seen = 1'b1;
      tick();
    end
    check("flush valid never", 64'(seen), 64'(0));
    run32("post-flush u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    // WIDTH=8: 200 / 3, valid in cycle 9
    sign8 = 1'b0; dd8 = 8'd200; dv8 = 8'd3; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 1;
    while (!valid8 && cyc < 30) begin
      tick();
      cyc++;
    end
    check("w8 latency",  64'(cyc),   64'(9));
    check("w8 quotient", 64'(quo8),  64'(66));
    check("w8 remainder",64'(rem8),  64'(2));
    check("w8 hilo",     64'(hilo8), 64'h0242);
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;

    // WIDTH=8: reset in cycle 4 aborts, all outputs zero in cycle 5
    sign8 = 1'b0; dd8 = 8'd200; dv8 = 8'd3; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int c = 1; c < 4; c++) tick();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    check("w8 rst busy",  64'(busy8),  64'(0));
    check("w8 rst valid", 64'(valid8), 64'(0));
    check("w8 rst stall", 64'(stall8), 64'(0));
    check("w8 rst hilo",  64'(hilo8),  64'(0));
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (valid8) seen = 1'b1;
      tick();
    end
    check("w8 rst no pulse", 64'(seen), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_div_iter

// File: doc/div_iter.md
# div_iter

Parametrised iterative radix-2 divider for the MiniMIPS32 execute stage. It is the multi-cycle successor to the single-cycle EXE arithmetic, and it serves DIV/DIVU at any datapath width. It computes signed or unsigned quotient and remainder, one bit per cycle. While busy it raises `stallreq_exe` into the SCU, and it presents `{HI,LO}` in the layout the hilo register expects. It is cancelled by the CP0 `flush`.

## Interface
- `WIDTH`, 32: operand and result width in bits, ≥ 2.
- `cpu_clk_50M` in 1: the single clock.
- `cpu_rst` in 1: synchronous, active-high reset.
- `start` in 1: request a division. Accepted only in IDLE.
- `sign` in 1: 1 = signed (DIV), 0 = unsigned (DIVU). Sampled with `start`.
- `dividend` in WIDTH: sampled with `start`.
- `divisor` in WIDTH: sampled with `start`.
- `flush` in 1: exception flush from CP0. Aborts any operation.
- `ack` in 1: consumer (EXE/MEM register) takes the result.
- `busy` out 1: state ≠ IDLE.
- `stallreq_exe` out 1: pipeline stall request to the SCU.
- `valid` out 1: result available (DONE state).
- `quotient` out WIDTH.
- `remainder` out WIDTH.
- `hilo` out 2·WIDTH: `{remainder, quotient}` (HI = remainder, LO = quotient).

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start & !flush` latches |dividend|, |divisor|, `sign`, neg_q = sign & (msb_dd ^ msb_dv) and neg_r = sign & msb_dd.
  - If the divisor is zero: go to DONE with quotient = all-ones and remainder = dividend unmodified. No sign fix-up is applied in this case.
  - Otherwise: clear the partial remainder, set count = 0, go to CALC.
- CALC, one restoring step per cycle:
  - r' = {r, q_msb}.
  - If r' ≥ |divisor|, subtract and shift 1 into q; otherwise shift 0.
  - count increments each step.
  - After the step with count = WIDTH−1, apply sign fix-up and go to DONE: negate q if neg_q, negate r if neg_r.
- Arithmetic rules:
  - Magnitudes are WIDTH-bit unsigned. The partial remainder is WIDTH+1 bits for the compare.
  - The most-negative value divided by −1 yields quotient = most-negative (wraps) and remainder = 0. No trap is raised.
- DONE:
  - Outputs are held stable.
  - `ack` returns to IDLE.
  - `start` in DONE is ignored.
- `flush` in any state returns to IDLE on the next edge and clears `valid`. Flush has priority over `start` and `ack`.
- `stallreq_exe` = (IDLE & start & !flush) | CALC. It is low in DONE, so the instruction advances with the result in that cycle.

## Timing
- Reset: state = IDLE. `busy`, `valid`, `stallreq_exe` = 0. `quotient`, `remainder`, `hilo` = 0.
- Reset mid-operation aborts without any output pulse.
- Latency for a non-zero divisor: `start` in cycle 0, CALC in cycles 1..WIDTH, `valid` = 1 from cycle WIDTH+1. For WIDTH = 32, `valid` appears in cycle 33.
- Latency for a zero divisor: `valid` = 1 in cycle 1.
- `valid` stays high until the cycle after `ack` or `flush`.
- Back-to-back operation: a new `start` is accepted in the cycle after the `ack` edge, at the earliest.
- `stallreq_exe` is combinational from `start`. All other outputs are registered.

## Structure
- `defines.v` holds:
  - the state encodings `DIV_IDLE`, `DIV_CALC`, `DIV_DONE`;
  - `DIV_STATE_BUS`;
  - the aluop codes for DIV/DIVU that EXE decodes to drive `start`/`sign`.
- Sub-module `div_step`: combinational single restoring step, parametrised by WIDTH. Inputs are the partial remainder, the quotient shift register and the divisor. Outputs are the next remainder and the next quotient.
- The top level holds the FSM, the counter (width $clog2(WIDTH)+1), the operand latches and the sign fix-up.

## Test plan
- Unsigned divide: WIDTH = 32, `sign` = 0, 100 / 7 → `valid` in cycle 33, `quotient` = 14, `remainder` = 2, `hilo` = 0x00000002_0000000E. `stallreq_exe` is high in cycles 0–32.
- Signed divide: −7 / 2 → `quotient` = 0xFFFFFFFD, `remainder` = 0xFFFFFFFF. Also 7 / −2 → `quotient` = 0xFFFFFFFD, `remainder` = 1.
- Divide by zero: 5 / 0 → `valid` in cycle 1, `quotient` = 0xFFFFFFFF, `remainder` = 5. `stallreq_exe` is high only in cycle 0.
- Overflow and unsigned full range:
  - Signed 0x80000000 / 0xFFFFFFFF → `quotient` = 0x80000000, `remainder` = 0.
  - Unsigned 0xFFFFFFFF / 1 → `quotient` = 0xFFFFFFFF, `remainder` = 0.
- Flush, hold and reset:
  - `flush` in cycle 10 of CALC → `busy` = 0 in cycle 11 and `valid` never rises. A following `start` (100 / 7) returns the correct result.
  - In DONE, hold `ack` low for 5 cycles → outputs are stable throughout. `ack` → `valid` = 0 on the next cycle.
- WIDTH = 8 parametrisation: unsigned 200 / 3 → `quotient` = 66, `remainder` = 2, `valid` in cycle 9. Also `cpu_rst` asserted in cycle 4 → all outputs are 0 in cycle 5.
